// File: rtl/signed_logic_pkg.sv
// Shared opcode encoding for the signed logic unit family.
// The low four codes keep the legacy 2-bit select meaning.
package signed_logic_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

endpackage

// File: rtl/signed_logic_core.sv
// Combinational bitwise operation plus zero / negative / parity flags.
// Signedness only matters for the negative flag (the MSB of the result).
module signed_logic_core
    import signed_logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             flag_zero_o,
    output logic             flag_neg_o,
    output logic             flag_par_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_NOTA:  result_o = ~a_i;
            OP_NAND:  result_o = ~(a_i & b_i);
            OP_NOR:   result_o = ~(a_i | b_i);
            OP_XNOR:  result_o = ~(a_i ^ b_i);
            default:  result_o = b_i;
        endcase
    end

    assign flag_zero_o = (result_o == '0);
    assign flag_neg_o  = result_o[WIDTH-1];
    assign flag_par_o  = ^result_o;

endmodule

// File: rtl/signed_logic_pipe.sv
// Two-stage signed logic unit with valid/ready flow control and a wrapping
// count of completed output handshakes.
module signed_logic_pipe
    import signed_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_par,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_neg_q, s2_neg_d;
    logic             s2_par_q, s2_par_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_neg;
    logic             core_par;

    signed_logic_core #(.WIDTH(WIDTH)) u_core (
        .a_i         (s1_a_q),
        .b_i         (s1_b_q),
        .op_i        (s1_op_q),
        .result_o    (core_result),
        .flag_zero_o (core_zero),
        .flag_neg_o  (core_neg),
        .flag_par_o  (core_par)
    );

    // Ready propagates backwards combinationally so a full pipe shifts in one cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = rst || s1_adv;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;
        s2_neg_d    = s2_neg_q;
        s2_par_d    = s2_par_q;
        count_d     = count_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = a;
                s1_b_d  = b;
                s1_op_d = op;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_zero_d   = core_zero;
                s2_neg_d    = core_neg;
                s2_par_d    = core_par;
            end
        end

        if (s2_valid_q && out_ready) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_par_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_neg_q    <= s2_neg_d;
            s2_par_q    <= s2_par_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign flag_zero = s2_zero_q;
    assign flag_neg  = s2_neg_q;
    assign flag_par  = s2_par_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_signed_logic_pipe.sv
// Directed + scoreboard bench for signed_logic_pipe: a 32-bit instance and an
// 8-bit instance with a 4-bit counter for the narrow-width and wrap cases.
module tb_signed_logic_pipe;
    import signed_logic_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, fz, fn, fp;
    logic [31:0] a, b, result;
    logic [2:0]  op;
    logic [15:0] op_count;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, fz8, fn8, fp8;
    logic [7:0]  a8, b8, result8;
    logic [2:0]  op8;
    logic [3:0]  op_count8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        bit          exact;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    logic [15:0] cnt32 = '0;
    logic [3:0]  cnt8  = '0;

    signed_logic_pipe #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_zero(fz), .flag_neg(fn), .flag_par(fp),
        .op_count(op_count)
    );

    signed_logic_pipe #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .flag_zero(fz8), .flag_neg(fn8), .flag_par(fp8),
        .op_count(op_count8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~x;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return ~(x ^ y);
            default: return y;
        endcase
    endfunction

    // Output monitors: pop the oldest expectation on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            q32.delete();
            cnt32 = '0;
        end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out32_unexpected: observed result %h expected no output", result);
            end else begin
                e = q32.pop_front();
                chk("out32_result", result, e.res);
                chk("out32_zero", 32'(fz), 32'(e.res == 32'd0));
                chk("out32_neg", 32'(fn), 32'(e.res[31]));
                chk("out32_par", 32'(fp), 32'(^e.res));
                if (e.exact) chk("out32_latency", 32'(cyc - e.cyc), 32'd2);
                cnt32 = cnt32 + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            q8.delete();
            cnt8 = '0;
        end else if (out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out8_unexpected: observed result %h expected no output", result8);
            end else begin
                e = q8.pop_front();
                chk("out8_result", 32'(result8), 32'(e.res[7:0]));
                chk("out8_zero", 32'(fz8), 32'(e.res[7:0] == 8'd0));
                chk("out8_neg", 32'(fn8), 32'(e.res[7]));
                chk("out8_par", 32'(fp8), 32'(^e.res[7:0]));
                if (e.exact) chk("out8_latency", 32'(cyc - e.cyc), 32'd2);
                cnt8 = cnt8 + 4'd1;
            end
        end
    end

    task automatic send32(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] rv, input bit exact);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        op = o;
        a  = av;
        b  = bv;
        n  = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL send32_timeout: observed in_ready %b expected 1 within 50 cycles", in_ready);
        end else begin
            e.res = rv;
            e.cyc = cyc;
            e.exact = exact;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] rv, input bit exact);
        exp_t e;
        int   n;
        in_valid8 = 1'b1;
        op8 = o;
        a8  = av;
        b8  = bv;
        n   = 0;
        @(negedge clk);
        while (in_ready8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready8 !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL send8_timeout: observed in_ready %b expected 1 within 50 cycles", in_ready8);
        end else begin
            e.res = 32'(rv);
            e.cyc = cyc;
            e.exact = exact;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] av, bv, r_hold;
        logic [7:0]  av8, bv8;
        logic [2:0]  o;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, fz, fn, fp}, 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst8_out_valid", 32'(out_valid8), 32'd0);
        chk("rst8_op_count", 32'(op_count8), 32'd0);
        rst = 1'b0;

        // Basic ops with exact two-cycle latency
        send32(OP_AND,   32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1);
        send32(OP_OR,    32'hFFFFFFFF, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b1);
        send32(OP_XOR,   32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
        send32(OP_NOTA,  32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00000000, 1'b1);
        send32(OP_NAND,  32'h0000FFFF, 32'h00FF00FF, 32'hFFFFFF00, 1'b1);
        send32(OP_NOR,   32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 1'b1);
        send32(OP_XNOR,  32'h0000FFFF, 32'h00FF00FF, 32'hFF0000FF, 1'b1);
        send32(OP_PASSB, 32'h0000FFFF, 32'h00FF00FF, 32'h00FF00FF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("basic_op_count", 32'(op_count), 32'd8);

        // Back-pressure from a freshly reset counter
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        send32(OP_XOR, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 1'b0);
        send32(OP_AND, 32'hA5A5A5A5, 32'h0000FFFF, 32'h0000A5A5, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        r_hold = 32'hEDCB5678;
        in_valid = 1'b1; op = OP_NOR; a = 32'h0F0F0000; b = 32'h000000F0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, r_hold);
        end
        out_ready = 1'b1;
        send32(OP_NOR, 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            chk("drain_op_count", 32'(op_count), 32'(k));
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset with two ops in flight
        out_ready = 1'b0;
        send32(OP_OR, 32'h11110000, 32'h00002222, 32'h11112222, 1'b0);
        send32(OP_OR, 32'h33330000, 32'h00004444, 32'h33334444, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send32(OP_XNOR, 32'hAAAA5555, 32'hAAAAAAAA, 32'hFFFF0000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_op_count", 32'(op_count), 32'd1);

        // Streaming random ops at full throughput
        for (int i = 0; i < 12; i++) begin
            o  = 3'($urandom_range(7));
            av = $urandom;
            bv = $urandom;
            send32(o, av, bv, model(o, av, bv), 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stream_op_count", 32'(op_count), 32'd13);
        chk("stream_model_count", 32'(op_count), 32'(cnt32));

        // Narrow instance: signed MSB case, then wrap of the 4-bit counter
        send8(OP_OR, 8'h80, 8'h01, 8'h81, 1'b1);
        for (int i = 0; i < 16; i++) begin
            o   = 3'($urandom_range(7));
            av8 = 8'($urandom);
            bv8 = 8'($urandom);
            send8(o, av8, bv8, 8'(model(o, 32'(av8), 32'(bv8))), 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("wrap8_op_count", 32'(op_count8), 32'd1);
        chk("wrap8_queue_empty", 32'(q8.size()), 32'd0);
        chk("final_queue32_empty", 32'(q32.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
